// File: rtl/btn_port_pkg.sv
// Shared definitions for the button input port: register offsets, bit
// positions within the register words and the event code type.
package btn_port_pkg;

  localparam logic [1:0] OFF_LEVEL = 2'd0;
  localparam logic [1:0] OFF_PRESS = 2'd1;
  localparam logic [1:0] OFF_EVENT = 2'd2;
  localparam logic [1:0] OFF_POP   = 2'd3;

  localparam int unsigned OVF_BIT       = 31;
  localparam int unsigned EVT_VALID_BIT = 31;

  localparam int unsigned EVT_CODE_W = 4;
  typedef logic [EVT_CODE_W-1:0] evt_code_t;

endpackage

// File: rtl/btn_debounce.sv
// Single-button synchroniser and debouncer.
//   clk    : block clock
//   rst    : synchronous active-high reset
//   raw_n  : raw asynchronous button, 0 = pressed
//   level  : debounced level, 1 = pressed
//   rise   : combinational, high in the cycle whose clock edge raises level
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_expire;

  assign w_differ = (r_sync2 != r_level);
  // Synced bit has differed for DEBOUNCE_CYCLES consecutive cycles.
  assign w_expire = w_differ && (r_cnt == CNT_LAST);

  // Two-flop synchroniser followed by the stability counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= ~raw_n;
      r_sync2 <= r_sync1;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_expire) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign level = r_level;
  // Aligned with the level update so the top records the press on the same edge.
  assign rise  = w_expire && !r_level;

endmodule

// File: rtl/btn_input_port.sv
// Memory-mapped button input peripheral with sticky press flags and an
// event FIFO.
//   clk     : block clock
//   rst     : synchronous active-high reset
//   btn_n   : raw buttons, 0 = pressed
//   addr    : bus word address
//   wr_data : bus write data
//   wr_en   : bus write strobe
//   hit     : combinational, addr inside BASE_ADDR..BASE_ADDR+3
//   rd_data : registered read data for the previous cycle's addr
//   irq     : registered, press flags set or FIFO nonempty
module btn_input_port
  import btn_port_pkg::*;
#(
  parameter int unsigned NBTN            = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter logic [15:0] BASE_ADDR       = 16'hFF10,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_n,
  input  logic [15:0]     addr,
  input  logic [31:0]     wr_data,
  input  logic            wr_en,
  output logic            hit,
  output logic [31:0]     rd_data,
  output logic            irq
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [NBTN-1:0]  w_level;
  logic [NBTN-1:0]  w_rise;

  logic [NBTN-1:0]  r_press;
  logic             r_ovf;
  logic [NBTN-1:0]  r_pend;
  evt_code_t        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_rd_data;
  logic             r_irq;

  logic [15:0]      w_rel;
  logic [1:0]       w_off;
  logic             w_press_wr;
  logic             w_pop_wr;
  logic             w_pop;
  logic             w_full;
  logic             w_has_pend;
  evt_code_t        w_push_idx;
  logic [NBTN-1:0]  w_pend_clr;
  logic             w_push;
  logic             w_drop;
  logic [NBTN-1:0]  w_press_clr;
  logic [NBTN-1:0]  w_press_nxt;
  logic             w_ovf_nxt;
  logic [NBTN-1:0]  w_pend_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [31:0]      w_rd_sel;
  logic             w_unused;

  // Per-button synchroniser and debouncer.
  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw_n (btn_n[g]),
      .level (w_level[g]),
      .rise  (w_rise[g])
    );
  end

  // Address decode; the unsigned offset check covers both range bounds.
  assign w_rel      = addr - BASE_ADDR;
  assign hit        = (w_rel < 16'd4);
  assign w_off      = w_rel[1:0];
  assign w_press_wr = wr_en && hit && (w_off == OFF_PRESS);
  assign w_pop_wr   = wr_en && hit && (w_off == OFF_POP);

  assign w_pop      = w_pop_wr && (r_count != '0);
  assign w_full     = (r_count == CNT_FULL);
  assign w_has_pend = |r_pend;

  // Lowest pending index wins the single push slot.
  always_comb begin
    w_push_idx = '0;
    for (int i = int'(NBTN) - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_push_idx = EVT_CODE_W'(i);
      end
    end
  end

  assign w_pend_clr  = w_has_pend ? (NBTN'(1) << w_push_idx) : '0;
  // A simultaneous pop frees the slot, so a full FIFO still accepts.
  assign w_push      = w_has_pend && (!w_full || w_pop);
  assign w_drop      = w_has_pend && w_full && !w_pop;

  // Set wins over write-1-to-clear for both press flags and overflow.
  assign w_press_clr = w_press_wr ? wr_data[NBTN-1:0] : '0;
  assign w_press_nxt = (r_press & ~w_press_clr) | w_rise;
  assign w_ovf_nxt   = (r_ovf && !(w_press_wr && wr_data[OVF_BIT])) || w_drop;
  assign w_pend_nxt  = (r_pend & ~w_pend_clr) | w_rise;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // Read data select.
  always_comb begin
    w_rd_sel = '0;
    case (w_off)
      OFF_LEVEL: w_rd_sel = 32'(w_level);
      OFF_PRESS: begin
        w_rd_sel          = 32'(r_press);
        w_rd_sel[OVF_BIT] = r_ovf;
      end
      OFF_EVENT: begin
        if (r_count != '0) begin
          w_rd_sel[EVT_VALID_BIT] = 1'b1;
          w_rd_sel[15:8]          = 8'(r_count);
          w_rd_sel[3:0]           = r_mem[r_rd_ptr];
        end
      end
      default: w_rd_sel = '0;
    endcase
  end

  // Flags, FIFO control, read data and interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_press   <= '0;
      r_ovf     <= 1'b0;
      r_pend    <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_press   <= w_press_nxt;
      r_ovf     <= w_ovf_nxt;
      r_pend    <= w_pend_nxt;
      r_count   <= w_count_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_rd_data <= hit ? w_rd_sel : '0;
      r_irq     <= (|w_press_nxt) || (w_count_nxt != '0);
    end
  end

  // FIFO storage needs no reset; the count marks valid entries.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= w_push_idx;
    end
  end

  assign rd_data  = r_rd_data;
  assign irq      = r_irq;

  assign w_unused = &{1'b0, wr_data[30:NBTN]};

endmodule
